output_blinker: RTL

- Output-side counterpart to the debounced key inputs. Turns one-tick event requests (e.g. a key's on-down pulse, a game event) into human-visible pulses on an LED or buzzer pin.
- Each blink has a fixed on-time and a guaranteed off-time.
- Requests that arrive while a blink is in progress are queued in a saturating counter and played back-to-back.
- Sits between the game/control logic and the board output pins, one instance per pin.

---
 rtl/output_blinker.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/output_blinker.sv
// ---------------------------------------------------------------------------
// output_blinker
//
// Purpose:
//   Converts one-tick event requests into human-visible pulses on an LED or
//   buzzer pin. Each blink is high for ON_TICKS cycles and then low for at
//   least OFF_TICKS cycles. Requests that arrive while a blink is running are
//   counted in a saturating pending counter and played back-to-back. The
//   `hold` input forces the pin active without affecting the sequencer.
//
// Ports:
//   clk      input            system clock
//   rst_n    input            synchronous active-low reset
//   trig     input            one-tick blink request (level = one per cycle)
//   hold     input            level, forces `out` high while asserted
//   out      output           registered pin drive, active high
//   busy     output           high whenever the sequencer is not idle
//   pending  output [PEND_W]  queued requests not yet started
//   done     output           one-tick pulse after the final off-phase
// ---------------------------------------------------------------------------
module output_blinker #(
    parameter int unsigned ON_TICKS  = 4000000,
    parameter int unsigned OFF_TICKS = 4000000,
    parameter int unsigned PEND_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig,
    input  logic              hold,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              done
);

    localparam int unsigned MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    // A one-cycle blink still needs a 1-bit timer to keep the vector legal.
    localparam int unsigned TW = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [TW-1:0]     ON_LOAD   = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0]     OFF_LOAD  = TW'(OFF_TICKS - 1);
    localparam logic [TW-1:0]     TIMER_ONE = TW'(1);
    localparam logic [TW-1:0]     TIMER_ZERO = '0;
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              out_q, out_d;
    logic              done_q, done_d;
    logic              inc, dec, startFromOff;

    // Next-state, timer and pending-counter logic. A trig that restarts the
    // sequencer from the last OFF cycle with nothing queued is consumed
    // directly instead of being counted as pending.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        pend_d       = pend_q;
        done_d       = 1'b0;
        dec          = 1'b0;
        startFromOff = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d = ST_ON;
                    timer_d = ON_LOAD;
                end
            end
            ST_ON: begin
                if (timer_q == TIMER_ZERO) begin
                    state_d = ST_OFF;
                    timer_d = OFF_LOAD;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            ST_OFF: begin
                if (timer_q == TIMER_ZERO) begin
                    if (pend_q != PEND_ZERO) begin
                        state_d = ST_ON;
                        timer_d = ON_LOAD;
                        dec     = 1'b1;
                    end else if (trig) begin
                        state_d      = ST_ON;
                        timer_d      = ON_LOAD;
                        startFromOff = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = TIMER_ZERO;
            end
        endcase

        inc = trig && (state_q != ST_IDLE) && !startFromOff;

        // Simultaneous inc and dec cancel, even at saturation.
        if (inc && !dec) begin
            if (pend_q != PEND_MAX) begin
                pend_d = pend_q + PEND_ONE;
            end
        end else if (dec && !inc) begin
            pend_d = pend_q - PEND_ONE;
        end

        out_d = (state_d == ST_ON) || hold;
    end

    // State register; reset aborts any blink in progress without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= TIMER_ZERO;
            pend_q  <= PEND_ZERO;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign out     = out_q;
    assign busy    = (state_q != ST_IDLE);
    assign pending = pend_q;
    assign done    = done_q;

endmodule
